// File: rtl/fpnew_opgroup_share_arb_if.sv
// Bundle of requester, shared-unit and response signals around the opgroup share arbiter.
// The slave modport is the arbiter's view; master is the surrounding requesters and shared unit.
interface fpnew_opgroup_share_arb_if #(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned PayloadW = 128,
    parameter int unsigned ResW     = 38,
    parameter int unsigned TagW     = 8,
    parameter int unsigned IdW      = (NumReq > 1) ? $clog2(NumReq) : 1
);
    logic [NumReq-1:0]          req_valid_i;
    logic [NumReq-1:0]          req_ready_o;
    logic [NumReq*PayloadW-1:0] req_payload_i;
    logic [NumReq*TagW-1:0]     req_tag_i;
    logic                       unit_valid_o;
    logic                       unit_ready_i;
    logic [PayloadW-1:0]        unit_payload_o;
    logic [IdW+TagW-1:0]        unit_tag_o;
    logic                       res_valid_i;
    logic                       res_ready_o;
    logic [IdW+TagW-1:0]        res_tag_i;
    logic [ResW-1:0]            res_data_i;
    logic [NumReq-1:0]          rsp_valid_o;
    logic [NumReq-1:0]          rsp_ready_i;
    logic [ResW-1:0]            rsp_data_o;
    logic [TagW-1:0]            rsp_tag_o;

    modport slave (
        input  req_valid_i, req_payload_i, req_tag_i, unit_ready_i,
               res_valid_i, res_tag_i, res_data_i, rsp_ready_i,
        output req_ready_o, unit_valid_o, unit_payload_o, unit_tag_o,
               res_ready_o, rsp_valid_o, rsp_data_o, rsp_tag_o
    );

    modport master (
        output req_valid_i, req_payload_i, req_tag_i, unit_ready_i,
               res_valid_i, res_tag_i, res_data_i, rsp_ready_i,
        input  req_ready_o, unit_valid_o, unit_payload_o, unit_tag_o,
               res_ready_o, rsp_valid_o, rsp_data_o, rsp_tag_o
    );
endinterface

// File: rtl/fpnew_opgroup_share_arb.sv
// Round-robin sharing of one opgroup datapath between NumReq requesters, with the
// requester id carried in the tag for result routing and per-requester credit limits.
module fpnew_opgroup_share_arb #(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned PayloadW = 128,
    parameter int unsigned ResW     = 38,
    parameter int unsigned TagW     = 8,
    parameter int unsigned MaxOutst = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    fpnew_opgroup_share_arb_if.slave       bus,
    output logic                           busy_o
);
    localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = $clog2(MaxOutst + 1);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                       state_reg, state_next;
    logic [IdW-1:0]               rr_ptr_reg, rr_ptr_next;
    logic [IdW-1:0]               lock_id_reg, lock_id_next;
    logic [NumReq-1:0][CntW-1:0]  credit_reg, credit_next;

    logic [NumReq-1:0]            eligible;
    logic [NumReq-1:0]            rsp_sel;
    logic [NumReq-1:0]            rsp_hs;
    logic [PayloadW-1:0]          payload_arr [NumReq];
    logic [TagW-1:0]              tag_arr     [NumReq];
    logic [IdW-1:0]               grant_idle;
    logic [IdW-1:0]               grant;
    logic [IdW-1:0]               grant_inc;
    logic [IdW-1:0]               res_id;
    logic                         id_ok;
    logic                         issue_hs;

    // Round-robin search starting at rr_ptr; only consulted while IDLE.
    always_comb begin
        int idx;
        logic found;
        grant_idle = rr_ptr_reg;
        found      = 1'b0;
        idx        = 0;
        for (int k = 0; k < int'(NumReq); k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= int'(NumReq)) idx = idx - int'(NumReq);
            if (!found && eligible[IdW'(idx)]) begin
                found      = 1'b1;
                grant_idle = IdW'(idx);
            end
        end
    end

    assign grant     = (state_reg == LOCKED) ? lock_id_reg : grant_idle;
    assign grant_inc = (grant == IdW'(NumReq - 1)) ? '0 : grant + 1'b1;

    // Outputs are forced inactive while reset is asserted, independent of the clock.
    assign bus.unit_valid_o   = rst_ni && ((state_reg == LOCKED) ? eligible[lock_id_reg] : |eligible);
    assign issue_hs           = bus.unit_valid_o && bus.unit_ready_i;
    assign bus.unit_payload_o = payload_arr[grant];
    assign bus.unit_tag_o     = {grant, tag_arr[grant]};

    assign res_id          = bus.res_tag_i[IdW+TagW-1:TagW];
    assign id_ok           = int'(res_id) < int'(NumReq);
    assign bus.res_ready_o = !id_ok || |(rsp_sel & bus.rsp_ready_i);
    assign bus.rsp_tag_o   = bus.res_tag_i[TagW-1:0];
    assign bus.rsp_data_o  = bus.res_data_i;

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
            logic [CntW-1:0] cnt_next;

            assign payload_arr[gi]     = bus.req_payload_i[gi*PayloadW +: PayloadW];
            assign tag_arr[gi]         = bus.req_tag_i[gi*TagW +: TagW];
            assign eligible[gi]        = bus.req_valid_i[gi] && (credit_reg[gi] < CntW'(MaxOutst));
            assign bus.req_ready_o[gi] = issue_hs && (grant == IdW'(gi));
            assign rsp_sel[gi]         = (res_id == IdW'(gi));
            assign bus.rsp_valid_o[gi] = rst_ni && bus.res_valid_i && rsp_sel[gi];
            assign rsp_hs[gi]          = bus.rsp_valid_o[gi] && bus.rsp_ready_i[gi];

            always_comb begin
                cnt_next = credit_reg[gi];
                if (flush_i) begin
                    cnt_next = '0;
                end else if (bus.req_ready_o[gi] && !rsp_hs[gi]) begin
                    cnt_next = credit_reg[gi] + 1'b1;
                end else if (!bus.req_ready_o[gi] && rsp_hs[gi] && credit_reg[gi] != '0) begin
                    cnt_next = credit_reg[gi] - 1'b1;
                end
            end

            assign credit_next[gi] = cnt_next;

            a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                !(rsp_hs[gi] && !flush_i && credit_reg[gi] == '0));
        end
    endgenerate

    a_res_id_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.res_valid_i && !id_ok));

    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        lock_id_next = lock_id_reg;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (issue_hs) begin
                        rr_ptr_next = grant_inc;
                    end else if (bus.unit_valid_o) begin
                        lock_id_next = grant;
                        state_next   = LOCKED;
                    end
                end
                LOCKED: begin
                    if (issue_hs) begin
                        rr_ptr_next = grant_inc;
                        state_next  = IDLE;
                    end else if (!bus.unit_valid_o) begin
                        // Requester withdrew (protocol violation): release rather than hang.
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            lock_id_reg <= '0;
            credit_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            lock_id_reg <= lock_id_next;
            credit_reg  <= credit_next;
        end
    end

    assign busy_o = (credit_reg != '0) || (state_reg == LOCKED);

endmodule

// File: tb/tb_fpnew_opgroup_share_arb.sv
// Directed bench for fpnew_opgroup_share_arb: arbitration order, locking, credits,
// response routing, flush and asynchronous reset.
module tb_fpnew_opgroup_share_arb;
    localparam int unsigned NumReq   = 4;
    localparam int unsigned PayloadW = 128;
    localparam int unsigned ResW     = 38;
    localparam int unsigned TagW     = 8;
    localparam int unsigned IdW      = 2;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    logic flush_i = 1'b0;
    logic busy_o;
    int   errors = 0;
    int   checks = 0;

    fpnew_opgroup_share_arb_if #(.NumReq(NumReq), .PayloadW(PayloadW), .ResW(ResW),
                                 .TagW(TagW), .IdW(IdW)) bus ();

    fpnew_opgroup_share_arb #(.NumReq(NumReq), .PayloadW(PayloadW), .ResW(ResW),
                              .TagW(TagW), .MaxOutst(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .flush_i(flush_i),
        .bus    (bus),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [PayloadW-1:0] exp_pl(input int k);
        return {96'h0, 32'hC0DE_0000 | 32'(k)};
    endfunction

    function automatic logic [IdW+TagW-1:0] exp_tag(input int k);
        return {IdW'(k), TagW'(8'h10 + k)};
    endfunction

    // Apply inputs on the falling edge, then let combinational outputs settle.
    task automatic cyc(input logic [3:0] v, input logic rdy);
        @(negedge clk_i);
        bus.req_valid_i  = v;
        bus.unit_ready_i = rdy;
        #1;
    endtask

    task automatic test_reset();
        bus.req_valid_i  = 4'b1111;
        bus.unit_ready_i = 1'b1;
        bus.res_valid_i  = 1'b1;
        bus.res_tag_i    = {2'd1, 8'h00};
        #1;
        checks++; if (bus.unit_valid_o !== 1'b0) begin errors++; $display("FAIL reset_unit_valid got=%b exp=0", bus.unit_valid_o); end
        checks++; if (bus.req_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready_o); end
        checks++; if (bus.rsp_valid_o !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0000", bus.rsp_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        @(negedge clk_i);
        bus.req_valid_i  = '0;
        bus.unit_ready_i = 1'b0;
        bus.res_valid_i  = 1'b0;
        rst_ni = 1'b1;
        $display("reset released");
    endtask

    task automatic test_round_robin();
        for (int c = 0; c < 8; c++) begin
            int k;
            k = c % 4;
            cyc(4'b1111, 1'b1);
            $display("rr issue cycle=%0d grant_vec=%b tag=%h", c, bus.req_ready_o, bus.unit_tag_o);
            checks++; if (bus.req_ready_o !== 4'(1 << k)) begin errors++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, bus.req_ready_o, 4'(1 << k)); end
            checks++; if (bus.unit_tag_o !== exp_tag(k)) begin errors++; $display("FAIL rr_tag c=%0d got=%h exp=%h", c, bus.unit_tag_o, exp_tag(k)); end
            checks++; if (bus.unit_payload_o !== exp_pl(k)) begin errors++; $display("FAIL rr_payload c=%0d got=%h exp=%h", c, bus.unit_payload_o, exp_pl(k)); end
        end
        cyc(4'b0000, 1'b0);
        checks++; if (dut.credit_reg[1] !== 3'd2) begin errors++; $display("FAIL rr_credit1 got=%0d exp=2", dut.credit_reg[1]); end
        flush_i = 1'b1;
        cyc(4'b0000, 1'b0);
        flush_i = 1'b0;
        cyc(4'b0000, 1'b0);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rr_flush_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_lock();
        cyc(4'b0110, 1'b0);
        checks++; if (bus.unit_valid_o !== 1'b1 || bus.unit_tag_o[9:8] !== 2'd1) begin errors++; $display("FAIL lock_first got_v=%b id=%0d exp 1/1", bus.unit_valid_o, bus.unit_tag_o[9:8]); end
        checks++; if (bus.req_ready_o !== 4'b0000) begin errors++; $display("FAIL lock_noready got=%b exp=0000", bus.req_ready_o); end
        cyc(4'b0111, 1'b0);
        checks++; if (bus.unit_tag_o !== exp_tag(1) || bus.unit_payload_o !== exp_pl(1)) begin errors++; $display("FAIL lock_hold tag=%h exp=%h", bus.unit_tag_o, exp_tag(1)); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL lock_busy got=%b exp=1", busy_o); end
        cyc(4'b0111, 1'b0);
        checks++; if (bus.unit_tag_o !== exp_tag(1)) begin errors++; $display("FAIL lock_hold2 tag=%h exp=%h", bus.unit_tag_o, exp_tag(1)); end
        cyc(4'b0111, 1'b1);
        $display("lock issue grant_vec=%b", bus.req_ready_o);
        checks++; if (bus.req_ready_o !== 4'b0010) begin errors++; $display("FAIL lock_release got=%b exp=0010", bus.req_ready_o); end
        cyc(4'b0101, 1'b1);
        $display("lock issue grant_vec=%b", bus.req_ready_o);
        checks++; if (bus.req_ready_o !== 4'b0100) begin errors++; $display("FAIL lock_next got=%b exp=0100", bus.req_ready_o); end
        flush_i = 1'b1;
        cyc(4'b0000, 1'b0);
        flush_i = 1'b0;
    endtask

    task automatic test_credit_limit();
        for (int c = 0; c < 4; c++) begin
            cyc(4'b0001, 1'b1);
            checks++; if (bus.req_ready_o !== 4'b0001) begin errors++; $display("FAIL cred_issue c=%0d got=%b exp=0001", c, bus.req_ready_o); end
        end
        cyc(4'b0001, 1'b1);
        checks++; if (bus.unit_valid_o !== 1'b0 || bus.req_ready_o !== 4'b0000) begin errors++; $display("FAIL cred_full v=%b r=%b exp 0/0000", bus.unit_valid_o, bus.req_ready_o); end
        checks++; if (dut.credit_reg[0] !== 3'd4) begin errors++; $display("FAIL cred_count got=%0d exp=4", dut.credit_reg[0]); end
        bus.res_valid_i = 1'b1;
        bus.res_tag_i   = {2'd0, 8'h10};
        bus.rsp_ready_i = 4'b0001;
        #1;
        checks++; if (bus.rsp_valid_o !== 4'b0001 || bus.res_ready_o !== 1'b1) begin errors++; $display("FAIL cred_rsp v=%b r=%b exp 0001/1", bus.rsp_valid_o, bus.res_ready_o); end
        checks++; if (bus.unit_valid_o !== 1'b0) begin errors++; $display("FAIL cred_same_cycle got=%b exp=0", bus.unit_valid_o); end
        @(negedge clk_i);
        bus.res_valid_i = 1'b0;
        bus.rsp_ready_i = 4'b0000;
        #1;
        checks++; if (bus.req_ready_o !== 4'b0001) begin errors++; $display("FAIL cred_resume got=%b exp=0001", bus.req_ready_o); end
        cyc(4'b0001, 1'b1);
        checks++; if (bus.unit_valid_o !== 1'b0) begin errors++; $display("FAIL cred_refull got=%b exp=0", bus.unit_valid_o); end
        flush_i = 1'b1;
        cyc(4'b0000, 1'b0);
        flush_i = 1'b0;
    endtask

    task automatic test_response();
        cyc(4'b0100, 1'b1);
        checks++; if (bus.req_ready_o !== 4'b0100) begin errors++; $display("FAIL rsp_setup got=%b exp=0100", bus.req_ready_o); end
        @(negedge clk_i);
        bus.req_valid_i = '0;
        bus.unit_ready_i = 1'b0;
        bus.res_valid_i = 1'b1;
        bus.res_tag_i   = {2'd2, 8'h5A};
        bus.res_data_i  = 38'h2A_DEAD_BEEF;
        bus.rsp_ready_i = 4'b0000;
        #1;
        checks++; if (bus.rsp_valid_o !== 4'b0100 || bus.res_ready_o !== 1'b0) begin errors++; $display("FAIL rsp_stall v=%b r=%b exp 0100/0", bus.rsp_valid_o, bus.res_ready_o); end
        checks++; if (bus.rsp_tag_o !== 8'h5A || bus.rsp_data_o !== 38'h2A_DEAD_BEEF) begin errors++; $display("FAIL rsp_data tag=%h data=%h exp 5a/2adeadbeef", bus.rsp_tag_o, bus.rsp_data_o); end
        @(negedge clk_i);
        checks++; if (dut.credit_reg[2] !== 3'd1) begin errors++; $display("FAIL rsp_nohs_credit got=%0d exp=1", dut.credit_reg[2]); end
        bus.rsp_ready_i = 4'b0100;
        #1;
        $display("rsp handshake id=2 tag=%h", bus.rsp_tag_o);
        checks++; if (bus.res_ready_o !== 1'b1) begin errors++; $display("FAIL rsp_ready got=%b exp=1", bus.res_ready_o); end
        @(negedge clk_i);
        bus.res_valid_i = 1'b0;
        bus.rsp_ready_i = 4'b0000;
        #1;
        checks++; if (dut.credit_reg[2] !== 3'd0 || busy_o !== 1'b0) begin errors++; $display("FAIL rsp_credit got=%0d busy=%b exp 0/0", dut.credit_reg[2], busy_o); end
    endtask

    task automatic test_back_to_back();
        cyc(4'b1000, 1'b1);
        @(negedge clk_i);
        bus.res_valid_i = 1'b1;
        bus.res_tag_i   = {2'd3, 8'h13};
        bus.rsp_ready_i = 4'b1000;
        #1;
        checks++; if (bus.req_ready_o !== 4'b1000 || bus.rsp_valid_o !== 4'b1000) begin errors++; $display("FAIL b2b_both iss=%b rsp=%b exp 1000/1000", bus.req_ready_o, bus.rsp_valid_o); end
        @(negedge clk_i);
        bus.req_valid_i = '0;
        #1;
        checks++; if (dut.credit_reg[3] !== 3'd1) begin errors++; $display("FAIL b2b_credit got=%0d exp=1", dut.credit_reg[3]); end
        @(negedge clk_i);
        bus.res_valid_i = 1'b0;
        bus.rsp_ready_i = 4'b0000;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_drain busy=%b exp=0", busy_o); end
    endtask

    task automatic test_flush_and_async_reset();
        cyc(4'b0001, 1'b1);
        cyc(4'b0001, 1'b1);
        cyc(4'b0010, 1'b1);
        cyc(4'b1000, 1'b1);
        cyc(4'b1000, 1'b1);
        cyc(4'b1000, 1'b1);
        cyc(4'b0010, 1'b0);
        checks++; if (dut.credit_reg !== {3'd3, 3'd0, 3'd1, 3'd2}) begin errors++; $display("FAIL fl_setup got=%h", dut.credit_reg); end
        cyc(4'b0010, 1'b1);
        flush_i = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b1 || bus.req_ready_o !== 4'b0010) begin errors++; $display("FAIL fl_before busy=%b r=%b exp 1/0010", busy_o, bus.req_ready_o); end
        cyc(4'b1001, 1'b0);
        flush_i = 1'b0;
        #1;
        checks++; if (dut.credit_reg !== '0 || busy_o !== 1'b0) begin errors++; $display("FAIL fl_after credits=%h busy=%b exp 0/0", dut.credit_reg, busy_o); end
        checks++; if (bus.unit_tag_o[9:8] !== 2'd0) begin errors++; $display("FAIL fl_rrptr id=%0d exp=0", bus.unit_tag_o[9:8]); end
        cyc(4'b1001, 1'b0);
        checks++; if (busy_o !== 1'b1 || bus.unit_valid_o !== 1'b1) begin errors++; $display("FAIL ar_locked busy=%b v=%b exp 1/1", busy_o, bus.unit_valid_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (bus.unit_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL ar_immediate v=%b busy=%b exp 0/0", bus.unit_valid_o, busy_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        bus.req_valid_i = 4'b0100;
        #1;
        checks++; if (bus.unit_valid_o !== 1'b1 || bus.unit_tag_o !== exp_tag(2)) begin errors++; $display("FAIL ar_after v=%b tag=%h exp 1/%h", bus.unit_valid_o, bus.unit_tag_o, exp_tag(2)); end
        cyc(4'b0000, 1'b0);
    endtask

    initial begin
        bus.req_valid_i  = '0;
        bus.unit_ready_i = 1'b0;
        bus.res_valid_i  = 1'b0;
        bus.res_tag_i    = '0;
        bus.res_data_i   = '0;
        bus.rsp_ready_i  = '0;
        for (int i = 0; i < 4; i++) begin
            bus.req_payload_i[i*PayloadW +: PayloadW] = exp_pl(i);
            bus.req_tag_i[i*TagW +: TagW]             = TagW'(8'h10 + i);
        end
        test_reset();
        test_round_robin();
        test_lock();
        test_credit_limit();
        test_response();
        test_back_to_back();
        test_flush_and_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fpnew_opgroup_share_arb.md
Name: fpnew_opgroup_share_arb

Overview:
- Shares one opgroup datapath (e.g. one ADDMUL block instance) between NumReq independent requesters, such as per-warp FPU issue ports.
- Arbitrates issue round-robin and embeds the requester index in the outgoing tag.
- Routes each result back to its owning requester by that index.
- Bounds in-flight operations per requester with credit counters.

Parameters:
- NumReq, 4: number of requesters (>=2).
- PayloadW, 128: width of the opaque operation bundle (operands, op, formats, rounding mode).
- ResW, 38: width of the opaque result bundle (result, status, ext bit).
- TagW, 8: requester-local tag width.
- MaxOutst, 4: maximum in-flight operations per requester (>=1).
- IdW, derived as max(1, clog2(NumReq)).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- flush_i  in  1  synchronous flush, forwarded to the shared unit
- req_valid_i  in  NumReq  per-requester issue valid
- req_ready_o  out  NumReq  per-requester issue ready
- req_payload_i  in  NumReq*PayloadW  per-requester operation bundle
- req_tag_i  in  NumReq*TagW  per-requester tag
- unit_valid_o  out  1  issue valid to the shared unit
- unit_ready_i  in  1  shared unit in_ready
- unit_payload_o  out  PayloadW  selected bundle
- unit_tag_o  out  IdW+TagW  {requester id, local tag}
- res_valid_i  in  1  shared unit out_valid
- res_ready_o  out  1  to shared unit out_ready
- res_tag_i  in  IdW+TagW  returned tag
- res_data_i  in  ResW  returned result bundle
- rsp_valid_o  out  NumReq  per-requester response valid
- rsp_ready_i  in  NumReq  per-requester response ready
- rsp_data_o  out  ResW  result, broadcast to all requesters
- rsp_tag_o  out  TagW  local tag, broadcast
- busy_o  out  1  any credit in use or lock held

Behaviour:
- Eligible(i) = req_valid_i[i] and credit[i] < MaxOutst.
- Issue FSM, IDLE/LOCKED:
  - IDLE: the grant goes to the first eligible requester at or after rr_ptr, wrapping modulo NumReq.
    - unit_valid_o = any eligible.
    - On unit_ready_i: handshake, rr_ptr <= grant+1 (wrap NumReq-1 -> 0), stay IDLE.
    - If valid without ready: latch grant into lock_id, go LOCKED.
  - LOCKED: grant = lock_id regardless of other requesters. The AXI rule holds: valid/payload stay stable until handshake, and the requester must keep valid asserted. On handshake: rr_ptr <= lock_id+1, go IDLE.
- req_ready_o[i] = unit_ready_i and (i == grant) and unit_valid_o. At most one bit is set.
- Issue is combinational, zero added latency. unit_tag_o = {grant id, req_tag_i[grant]}.
- Credit counters, width clog2(MaxOutst+1):
  - Increment on issue handshake of requester i.
  - Decrement on response handshake to requester i.
  - Both in the same cycle: unchanged.
  - A full counter makes the requester ineligible. It is never granted, including in the IDLE selection.
- Response path, combinational:
  - id = res_tag_i[IdW+TagW-1:TagW].
  - rsp_valid_o[id] = res_valid_i, all other bits 0.
  - res_ready_o = rsp_ready_i[id].
  - rsp_tag_o = low TagW bits of res_tag_i.
  - A returned id >= NumReq drops the result: res_ready_o=1, no rsp_valid. Assertion fires.
- Credit underflow (response while credit==0) is an assertion error. The counter saturates at 0.
- Flush (flush_i=1): all credits <=0, FSM -> IDLE, rr_ptr retained. Issue handshakes and response handshakes in the flush cycle are ignored for counting.
- Reset values: rr_ptr=0, FSM=IDLE, credits=0, lock_id=0.
  - Outputs: unit_valid_o=0, req_ready_o=0, rsp_valid_o=0, busy_o=0.
  - unit_* and rsp_* data are don't care.
- Reset mid-operation discards all in-flight state. The shared unit is reset by the same rst_ni.
- busy_o = any credit != 0 or FSM==LOCKED.

Test Plan:
- All 4 requesters valid every cycle, unit_ready_i=1 -> grants 0,1,2,3,0,... one per cycle; unit_tag_o id field matches.
- Req1 and req2 valid, unit_ready_i=0 for 3 cycles -> grant locked on 1 with stable payload. Req0 asserting in cycle 2 does not steal the grant. When ready rises, 1 issues, then 2.
- MaxOutst=4, req0 alone, 4 issues with no responses -> req_ready_o[0]=0 and unit_valid_o=0 from the 5th attempt. One response to id0 -> issue resumes the next cycle.
- res_tag_i={id=2, tag=0x5A}, rsp_ready_i[2]=0 -> rsp_valid_o=0100, res_ready_o=0. rsp_ready_i[2]=1 -> handshake, credit[2] decremented, rsp_tag_o=0x5A.
- Simultaneous issue and response for req3 in one cycle -> credit[3] unchanged.
- Credits {2,1,0,3} with flush_i for one cycle -> all credits 0, FSM IDLE, busy_o=0 the next cycle. Asserting rst_ni low asynchronously mid-LOCKED -> unit_valid_o=0 immediately.
